lcd_scan_out: RTL and testbench
===============================

# lcd_scan_out

Downstream display-scan stage for the image display controller. After the controller finishes writing the processed 8×8 image into IRAM, this block reads IRAM through a synchronous read port and streams the 64 pixels to the LCD panel interface in raster order. The stream uses a valid/ready handshake, row/column sideband and line/frame markers, with optional horizontal mirroring. A 2-entry prefetch buffer absorbs the 1-cycle RAM read latency and panel back-pressure.

## Interface
- DATA_W, 8, pixel width
- ROWS, 8, image rows (power of two)
- COLS, 8, image columns (power of two)
- ADDR_W, 6, RAM address width; must equal log2(ROWS*COLS)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  scan request; sampled only in IDLE or DONE
- mirror  in  1  horizontal mirror; latched with accepted start
- ram_rd  out  1  RAM read strobe
- ram_A  out  ADDR_W  RAM read address, row-major (row*COLS+col)
- ram_Q  in  DATA_W  RAM read data; valid in the cycle after ram_rd/ram_A are presented
- pix_data  out  DATA_W  pixel to panel
- pix_valid  out  1  pix_data and sideband valid
- pix_ready  in  1  panel accepts; transfer = pix_valid & pix_ready at a rising edge
- pix_row  out  log2(ROWS)  display row of current pixel
- pix_col  out  log2(COLS)  display column of current pixel
- line_end  out  1  pix_col == COLS-1 (qualified by pix_valid)
- frame_end  out  1  last pixel of frame (qualified by pix_valid)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after last transfer

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: busy=0, ram_rd=0, pix_valid=0. start=1 → SCAN; latch mirror; reset read counter and output counter to 0.
- SCAN: busy=1. Read counter walks display order 0..ROWS*COLS-1. Display (r,c) maps to ram_A = r*COLS + (mirror ? COLS-1-c : c).
- Read issue rule: ram_rd=1 in a cycle only if reads remain AND (buffer entries + reads in flight − pop this cycle) ≤ 1. Buffer never overflows.
- The RAM word returned in the cycle after a read is written into the 2-entry FIFO at the next edge. Each word carries its display (r,c).
- pix_valid = FIFO non-empty. pix_data, pix_row, pix_col, line_end and frame_end come from the FIFO head.
- While pix_valid=1 and pix_ready=0, all pixel outputs hold stable.
- A transfer on the 64th pixel (frame_end=1) → DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then → IDLE. start=1 in DONE → SCAN directly. done still pulses that cycle.
- start in SCAN is ignored. mirror is only sampled with an accepted start.
- Counters wrap naturally at ROWS*COLS. No partial frames.
- reset at any time, including mid-scan: immediately returns to IDLE, empties the FIFO, deasserts all outputs. No done pulse.

## Timing
- Reset values: busy=0, done=0, ram_rd=0, ram_A=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, line_end=0, frame_end=0.
- start sampled at edge N → after N: busy=1, ram_rd=1, ram_A=first address.
- Data captured at edge N+2 → pix_valid=1 after N+2 (first-pixel latency 2 cycles).
- With pix_ready held 1: one pixel per cycle, no bubbles. Pixel i transfers at edge N+3+i; last pixel at N+66.
- done=1 during the cycle after N+66; IDLE after N+67.
- Back-pressure: when pix_ready falls, at most 2 entries are buffered and ram_rd drops within one cycle. When pix_ready rises, throughput resumes at 1/cycle with no lost or duplicated pixel.
- All outputs are registered. No combinational path from pix_ready to pix_valid/pix_data; the ram_rd issue decision may use pix_ready.

## Test plan
- Basic scan: RAM[k]=k, mirror=0, pix_ready=1, start pulse → 64 transfers with data 0x00..0x3F; (row,col) (0,0)..(7,7); line_end on cols 7; frame_end only on data 0x3F; first pix_valid 2 cycles after start; done 66 cycles after start, one cycle wide.
- Mirror: same RAM, mirror=1 → row 0 outputs 0x07..0x00, row 7 outputs 0x3F..0x38; pix_col still counts 0..7.
- Back-pressure: pix_ready pseudo-random 50%, plus a 10-cycle stall at pixel 20 → data identical to basic scan; outputs stable during stalls; never more than 2 reads outstanding-or-buffered.
- Start handling: start held high through SCAN → exactly one frame; start in the DONE cycle → second frame begins with no IDLE cycle; done pulses once per frame.
- Reset mid-scan: assert reset asynchronously after pixel 30 → all outputs go to reset values immediately; a new start afterward produces a clean full frame from pixel 0.
- Panel model check: capture stream into an 8×8 array and compare against the RAM image (and its mirrored form) for the reset-then-rescan sequence.

Source files
------------

// File: rtl/lcd_scan_out.sv
// Display scan-out stage: reads an 8x8 image from a synchronous-read IRAM and streams
// it to the LCD panel in raster order over valid/ready, with optional horizontal mirroring.
module lcd_scan_out #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mirror,
    output logic                      ram_rd,
    output logic [ADDR_W-1:0]         ram_A,
    input  logic [DATA_W-1:0]         ram_Q,
    output logic [DATA_W-1:0]         pix_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [$clog2(ROWS)-1:0]   pix_row,
    output logic [$clog2(COLS)-1:0]   pix_col,
    output logic                      line_end,
    output logic                      frame_end,
    output logic                      busy,
    output logic                      done
);

    localparam int                CW       = $clog2(COLS);
    localparam logic [ADDR_W:0]   PIX_CNT  = (ADDR_W+1)'(ROWS*COLS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS*COLS-1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state_q, state_d;

    // Read side: display index of the next read, latched mirror, and the read in flight.
    logic [ADDR_W:0]   rd_cnt_q,   rd_cnt_d;
    logic              mirror_q,   mirror_d;
    logic              infl_q,     infl_d;
    logic [ADDR_W-1:0] infl_idx_q, infl_idx_d;

    // Two-entry prefetch FIFO; each entry carries its display index alongside the pixel.
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [ADDR_W-1:0] fifo_idx_q  [2];
    logic [ADDR_W-1:0] fifo_idx_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;

    logic              start_acc;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] cur_idx;
    logic [CW-1:0]     cur_col;
    logic [ADDR_W-1:0] head_idx;

    assign pix_valid = (count_q != 2'd0);
    assign head_idx  = fifo_idx_q[rd_ptr_q];
    assign start_acc = start && (state_q != SCAN);
    assign pop       = pix_valid && pix_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (pop && head_idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read issue and FIFO bookkeeping
    always_comb begin
        cur_idx   = rd_cnt_q[ADDR_W-1:0];
        cur_col   = cur_idx[CW-1:0];
        // Slots already committed after this cycle's pop; a new read is allowed only if one stays free.
        occupancy = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
        issue     = (state_q == SCAN) && (rd_cnt_q < PIX_CNT) && (occupancy <= 3'd1);

        rd_cnt_d   = start_acc ? '0 : rd_cnt_q + {{ADDR_W{1'b0}}, issue};
        mirror_d   = start_acc ? mirror : mirror_q;
        infl_d     = issue;
        infl_idx_d = cur_idx;

        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (infl_q) begin
            fifo_data_d[wr_ptr_q] = ram_Q;
            fifo_idx_d[wr_ptr_q]  = infl_idx_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, infl_q} - {1'b0, pop};
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q   <= '0;
            mirror_q   <= 1'b0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            // NOTE: the buffer is two flops deep and drives outputs directly, so it is reset like any other state.
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            rd_cnt_q    <= rd_cnt_d;
            mirror_q    <= mirror_d;
            infl_q      <= infl_d;
            infl_idx_q  <= infl_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_idx_q  <= fifo_idx_d;
        end
    end

    // Output logic: a decode of registered state; only ram_rd looks at pix_ready.
    always_comb begin
        busy      = (state_q == SCAN);
        done      = (state_q == DONE);
        ram_rd    = issue;
        ram_A     = {cur_idx[ADDR_W-1:CW], mirror_q ? ~cur_col : cur_col};
        pix_data  = fifo_data_q[rd_ptr_q];
        pix_row   = head_idx[ADDR_W-1:CW];
        pix_col   = head_idx[CW-1:0];
        line_end  = pix_valid && (&head_idx[CW-1:0]);
        frame_end = pix_valid && (head_idx == LAST_IDX);
    end

endmodule

// File: tb/tb_lcd_scan_out.sv
// Bench for lcd_scan_out: synchronous RAM model, random panel back-pressure, and a
// frame-level reference model checked against the DUT outputs every cycle.
module tb_lcd_scan_out;

    localparam int NPIX = 64;

    logic       clk, reset, start, mirror, pix_ready;
    logic       ram_rd, pix_valid, line_end, frame_end, busy, done;
    logic [5:0] ram_A;
    logic [7:0] ram_Q, pix_data;
    logic [2:0] pix_row, pix_col;

    lcd_scan_out dut (
        .clk(clk), .reset(reset), .start(start), .mirror(mirror),
        .ram_rd(ram_rd), .ram_A(ram_A), .ram_Q(ram_Q),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_row(pix_row), .pix_col(pix_col), .line_end(line_end),
        .frame_end(frame_end), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [NPIX];

    // Synchronous-read RAM; garbage on non-read cycles exposes mistimed captures.
    always @(posedge clk) begin
        if (ram_rd) ram_Q <= mem[ram_A];
        else        ram_Q <= 8'($urandom);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display position -> RAM address for a given mirror setting.
    function automatic int exp_addr(input int idx, input bit m);
        int r, c;
        r = idx / 8;
        c = idx % 8;
        return r * 8 + (m ? 7 - c : c);
    endfunction

    // Frame-level reference model state.
    bit         m_busy, m_done, m_mirror, prev_hold, xfer;
    int         m_idx, m_reads, n_started, n_done;
    int         cap [NPIX];
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_outs", {ram_rd, ram_A, busy, done, pix_valid, pix_data,
                                 pix_row, pix_col, line_end, frame_end}, 32'd0);
            m_busy = 0; m_done = 0; m_idx = 0; m_reads = 0; prev_hold = 0;
        end else begin
            xfer = pix_valid && pix_ready;
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (!m_busy) check("idle_quiet", {pix_valid, ram_rd}, 0);
            if (prev_hold) begin
                check("hold_valid", pix_valid, 1);
                check("hold_data", pix_data, prev_data);
            end
            if (pix_valid && m_busy && m_idx < NPIX) begin
                check("pix_data",  pix_data,  mem[exp_addr(m_idx, m_mirror)]);
                check("pix_row",   pix_row,   m_idx / 8);
                check("pix_col",   pix_col,   m_idx % 8);
                check("line_end",  line_end,  (m_idx % 8) == 7);
                check("frame_end", frame_end, m_idx == NPIX - 1);
            end
            if (ram_rd && m_busy) begin
                check("read_in_range", m_reads < NPIX, 1);
                check("ram_A", ram_A, exp_addr(m_reads % NPIX, m_mirror));
            end
            if (m_busy) check("occupancy", (m_reads + int'(ram_rd)) - (m_idx + int'(xfer)) <= 2, 1);
            if (done) n_done++;
            prev_hold = pix_valid && !pix_ready;
            prev_data = pix_data;

            if (m_busy) begin
                m_reads += int'(ram_rd);
                if (xfer) begin
                    cap[int'(pix_row) * 8 + int'(pix_col)] = int'(pix_data);
                    m_idx++;
                    if (m_idx == NPIX) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else begin
                m_done = 0;
                if (start) begin
                    m_busy = 1; m_idx = 0; m_reads = 0; m_mirror = mirror;
                    n_started++;
                    for (int i = 0; i < NPIX; i++) cap[i] = -1;
                end
            end
        end
    end

    // Panel ready: mode 0 always ready, mode 1 random with one 10-cycle stall at pixel 20.
    int ready_mode = 0;
    int stall_left = 0;
    bit stalled    = 0;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            pix_ready = 1'b1;
            stalled   = 0;
        end else if (stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
        end else if (!stalled && m_busy && m_idx == 20) begin
            stalled    = 1;
            stall_left = 9;
            pix_ready  = 1'b0;
        end else begin
            pix_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit m);
        start  = 1'b1;
        mirror = m;
        step();
        start  = 1'b0;
        mirror = 1'($urandom);
    endtask

    task automatic wait_done(input int bound, output int k);
        k = 0;
        while (!done && k < bound) begin
            step();
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_image(input string name, input bit m);
        int bad;
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (cap[i] != int'(mem[exp_addr(i, m)])) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int k, d0;
        reset = 1'b1; start = 1'b0; mirror = 1'b0; pix_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        repeat (3) step();
        check("por_outs", {ram_rd, ram_A, busy, done, pix_valid, pix_data}, 0);
        reset = 1'b0;
        step();

        // Basic scan with exact latencies.
        d0 = n_done;
        pulse_start(0);
        check("start_busy", busy, 1);
        check("start_rd", ram_rd, 1);
        check("start_addr", ram_A, 0);
        k = 0;
        while (!pix_valid && k < 10) begin step(); k++; end
        check("first_valid_lat", k, 2);
        while (!done && k < 300) begin step(); k++; end
        check("done_lat", k, 66);
        step();
        check("done_width", {done, busy}, 0);
        check("done_count_basic", n_done - d0, 1);
        check_image("img_basic", 0);
        check("basic_px0", cap[0], 0);
        check("basic_px63", cap[63], 8'h3F);

        // Mirror.
        pulse_start(1);
        wait_done(300, k);
        step();
        check_image("img_mirror", 1);
        check("mirror_r0c0", cap[0], 8'h07);
        check("mirror_r7c0", cap[56], 8'h3F);
        check("mirror_r7c7", cap[63], 8'h38);

        // Back-pressure with random image.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        ready_mode = 1;
        pulse_start(0);
        wait_done(2000, k);
        step();
        check_image("img_backpressure", 0);
        ready_mode = 0;
        step();

        // Start held through the scan; mirror wiggles after acceptance.
        d0 = n_done;
        start = 1'b1; mirror = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            mirror = 1'($urandom);
        end
        start = 1'b0;
        wait_done(300, k);
        repeat (3) step();
        check("held_start_idle", busy, 0);
        check("held_start_frames", n_done - d0, 1);
        check_image("img_held", 0);

        // Start in the DONE cycle: next frame without an IDLE cycle.
        d0 = n_done;
        pulse_start(1);
        wait_done(300, k);
        start = 1'b1; mirror = 1'b0;
        step();
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        wait_done(300, k);
        step();
        check_image("img_b2b", 0);
        check("b2b_frames", n_done - d0, 2);

        // Reset mid-scan, then a clean mirrored rescan.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        d0 = n_done;
        pulse_start(1);
        k = 0;
        while (m_idx <= 30 && k < 200) begin step(); k++; end
        #2 reset = 1'b1;
        #1 check("async_reset_outs", {ram_rd, ram_A, busy, done, pix_valid, pix_data,
                                      pix_row, pix_col, line_end, frame_end}, 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        check("reset_no_done", n_done - d0, 0);
        pulse_start(1);
        wait_done(300, k);
        step();
        check_image("img_rescan", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
